// File: rtl/dco_dctrl_dither.sv
// rtl/dco_dctrl_dither.sv - FCW to DCTRL front end with 1st-order/MASH 1-1 dither, band settle and windowed sum.
module dco_dctrl_dither #(
  parameter int INT_W      = 9,
  parameter int FRAC_W     = 8,
  parameter int SETTLE_CYC = 16,
  parameter int OSR        = 100
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          EN,
  input  logic [INT_W-1:0]              FCW_INT,
  input  logic [FRAC_W-1:0]             FCW_FRAC,
  input  logic [1:0]                    DITH_MODE,
  input  logic [1:0]                    BAND_REQ,
  input  logic                          BAND_LD,
  output logic [INT_W-1:0]              DCTRL,
  output logic [1:0]                    BAND,
  output logic                          BAND_BUSY,
  output logic [INT_W+$clog2(OSR):0]    AVG_SUM,
  output logic                          AVG_VLD
);

  localparam int SUM_W  = INT_W + $clog2(OSR) + 1;
  localparam int SCNT_W = $clog2(SETTLE_CYC + 1);
  localparam int WCNT_W = $clog2(OSR + 1);
  localparam int CODE_W = INT_W + 2;
  localparam logic [INT_W-1:0] MID = {1'b1, {(INT_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_SETTLE = 2'd2
  } state_t;

  state_t              state, state_n;
  logic [FRAC_W-1:0]   acc1, acc1_n, acc2, acc2_n;
  logic                c2d, c2d_n;
  logic [INT_W-1:0]    dctrl, dctrl_n;
  logic [1:0]          band, band_n;
  logic [SCNT_W-1:0]   scnt, scnt_n;
  logic [WCNT_W-1:0]   wcnt, wcnt_n;
  logic [SUM_W-1:0]    sum, sum_n, sum_add, avg_sum, avg_sum_n;
  logic                avg_vld, avg_vld_n;

  logic [FRAC_W:0]     s1, s2;
  logic                c1, c2;
  logic signed [CODE_W-1:0] fcw_s, c1_s, c2_s, c2d_s, code;
  logic [INT_W-1:0]    code_sat;

  // Both accumulator stages share the same cycle: acc2 integrates the new acc1 value.
  always_comb begin
    s1    = {1'b0, acc1} + {1'b0, FCW_FRAC};
    c1    = s1[FRAC_W];
    s2    = {1'b0, acc2} + {1'b0, s1[FRAC_W-1:0]};
    c2    = s2[FRAC_W];
    fcw_s = $signed({2'b00, FCW_INT});
    c1_s  = $signed({{(CODE_W-1){1'b0}}, c1});
    c2_s  = $signed({{(CODE_W-1){1'b0}}, c2});
    c2d_s = $signed({{(CODE_W-1){1'b0}}, c2d});
    case (DITH_MODE)
      2'd1:    code = fcw_s + c1_s;
      2'd2:    code = fcw_s + c1_s + c2_s - c2d_s;
      default: code = fcw_s;
    endcase
    if (code[CODE_W-1])
      code_sat = '0;
    else if (code[INT_W])
      code_sat = '1;
    else
      code_sat = code[INT_W-1:0];
  end

  always_comb begin
    state_n   = state;
    dctrl_n   = MID;
    acc1_n    = '0;
    acc2_n    = '0;
    c2d_n     = 1'b0;
    band_n    = band;
    scnt_n    = '0;
    wcnt_n    = '0;
    sum_n     = '0;
    sum_add   = '0;
    avg_sum_n = avg_sum;
    avg_vld_n = 1'b0;
    case (state)
      S_IDLE: begin
        if (EN) state_n = S_RUN;
      end
      S_SETTLE: begin
        if (!EN)
          state_n = S_IDLE;
        else if (scnt == SCNT_W'(SETTLE_CYC - 1))
          state_n = S_RUN;
        else
          scnt_n = scnt + 1'b1;
      end
      S_RUN: begin
        if (!EN) begin
          state_n = S_IDLE;
        end else if (BAND_LD && BAND_REQ != 2'd3 && BAND_REQ != band) begin
          state_n = S_SETTLE;
          band_n  = BAND_REQ;
        end else begin
          dctrl_n = code_sat;
          acc1_n  = s1[FRAC_W-1:0];
          if (DITH_MODE == 2'd2) begin
            acc2_n = s2[FRAC_W-1:0];
            c2d_n  = c2;
          end
          // Window closes on the OSR-th addition; the next one starts on the following cycle.
          sum_add = sum + SUM_W'(dctrl_n);
          if (wcnt == WCNT_W'(OSR - 1)) begin
            avg_sum_n = sum_add;
            avg_vld_n = 1'b1;
          end else begin
            wcnt_n = wcnt + 1'b1;
            sum_n  = sum_add;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= S_IDLE;
      dctrl   <= MID;
      acc1    <= '0;
      acc2    <= '0;
      c2d     <= 1'b0;
      band    <= 2'd0;
      scnt    <= '0;
      wcnt    <= '0;
      sum     <= '0;
      avg_sum <= '0;
      avg_vld <= 1'b0;
    end else begin
      state   <= state_n;
      dctrl   <= dctrl_n;
      acc1    <= acc1_n;
      acc2    <= acc2_n;
      c2d     <= c2d_n;
      band    <= band_n;
      scnt    <= scnt_n;
      wcnt    <= wcnt_n;
      sum     <= sum_n;
      avg_sum <= avg_sum_n;
      avg_vld <= avg_vld_n;
    end
  end

  assign DCTRL     = dctrl;
  assign BAND      = band;
  assign BAND_BUSY = (state == S_SETTLE);
  assign AVG_SUM   = avg_sum;
  assign AVG_VLD   = avg_vld;

endmodule

// File: tb/tb_dco_dctrl_dither.sv
// tb/tb_dco_dctrl_dither.sv - scoreboard bench for dco_dctrl_dither against a behavioural model.
module tb_dco_dctrl_dither;

  localparam int INT_W = 9, FRAC_W = 8, SETTLE_CYC = 16, OSR = 100;
  localparam int MID = 256, MAXC = 511, FMOD = 256;
  localparam int M_IDLE = 0, M_RUN = 1, M_SETTLE = 2;

  logic clk = 1'b0;
  logic rst = 1'b1, en = 1'b0, band_ld = 1'b0;
  logic [INT_W-1:0]  fcw_int = '0;
  logic [FRAC_W-1:0] fcw_frac = '0;
  logic [1:0] dith_mode = 2'd0, band_req = 2'd0;
  logic [INT_W-1:0] dctrl;
  logic [1:0] band;
  logic band_busy, avg_vld;
  logic [INT_W+$clog2(OSR):0] avg_sum;

  dco_dctrl_dither #(.INT_W(INT_W), .FRAC_W(FRAC_W), .SETTLE_CYC(SETTLE_CYC), .OSR(OSR)) dut (
    .CLK(clk), .RST(rst), .EN(en), .FCW_INT(fcw_int), .FCW_FRAC(fcw_frac),
    .DITH_MODE(dith_mode), .BAND_REQ(band_req), .BAND_LD(band_ld),
    .DCTRL(dctrl), .BAND(band), .BAND_BUSY(band_busy), .AVG_SUM(avg_sum), .AVG_VLD(avg_vld)
  );

  always #5 clk = ~clk;

  typedef struct {
    int dctrl; int band; int busy; int vld; int avg_sum; int tag;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0, failures = 0;
  int phase = 0;

  // Model state: mode of operation, settle cycles elapsed, fractional phases, window contents.
  int m_st = M_IDLE, m_dctrl = MID, m_band = 0, m_settled = 0;
  int m_a1 = 0, m_a2 = 0, m_prev_c2 = 0;
  int m_win[$];
  int m_avg = 0, m_vld = 0;

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_rng(string name, int act, int lo, int hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d..%0d t=%0t", name, act, lo, hi, $time);
    end
  endtask

  task automatic model_clear();
    m_a1 = 0; m_a2 = 0; m_prev_c2 = 0;
    m_win.delete();
    m_dctrl = MID;
  endtask

  task automatic model_step();
    exp_t e;
    int tag = 0;
    m_vld = 0;
    if (rst) begin
      m_st = M_IDLE; m_band = 0; m_avg = 0; m_settled = 0;
      model_clear();
    end else if (m_st == M_IDLE) begin
      model_clear();
      if (en) m_st = M_RUN;
    end else if (m_st == M_SETTLE) begin
      model_clear();
      if (!en) m_st = M_IDLE;
      else begin
        m_settled++;
        if (m_settled == SETTLE_CYC) m_st = M_RUN;
      end
    end else begin
      if (!en) begin
        m_st = M_IDLE;
        model_clear();
      end else if (band_ld && band_req <= 2 && int'(band_req) != m_band) begin
        m_st = M_SETTLE; m_band = band_req; m_settled = 0;
        model_clear();
      end else begin
        int total1, total2, c1, c2, code;
        total1 = m_a1 + int'(fcw_frac);
        c1 = total1 / FMOD;
        m_a1 = total1 % FMOD;
        code = fcw_int;
        if (dith_mode == 2'd1) begin
          code += c1;
          m_a2 = 0; m_prev_c2 = 0;
        end else if (dith_mode == 2'd2) begin
          total2 = m_a2 + m_a1;
          c2 = total2 / FMOD;
          m_a2 = total2 % FMOD;
          code += c1 + c2 - m_prev_c2;
          m_prev_c2 = c2;
        end else begin
          m_a2 = 0; m_prev_c2 = 0;
        end
        m_dctrl = (code < 0) ? 0 : (code > MAXC) ? MAXC : code;
        tag = phase;
        m_win.push_back(m_dctrl);
        if (m_win.size() == OSR) begin
          m_avg = m_win.sum();
          m_vld = 1;
          m_win.delete();
        end
      end
    end
    e.dctrl = m_dctrl; e.band = m_band; e.busy = (m_st == M_SETTLE);
    e.vld = m_vld; e.avg_sum = m_avg; e.tag = tag;
    exp_q.push_back(e);
  endtask

  task automatic cycles(int n);
    repeat (n) begin
      model_step();
      @(negedge clk);
    end
  endtask

  // Monitor: one expectation per clock edge, compared 1 time unit after the edge.
  int prev2 = -1, win3 = 0, tot3 = 0;
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("dctrl", dctrl, e.dctrl);
      check("band", band, e.band);
      check("band_busy", band_busy, e.busy);
      check("avg_vld", avg_vld, e.vld);
      if (e.vld) check("avg_sum", avg_sum, e.avg_sum);
      if (e.tag == 2) begin
        check_rng("fo_dctrl", dctrl, 100, 101);
        if (prev2 >= 0) checks++;
        if (prev2 >= 0 && int'(dctrl) == prev2) begin
          failures++;
          $display("FAIL fo_alternate actual=%0d expected=%0d", dctrl, 201 - prev2);
        end
        prev2 = dctrl;
        if (avg_vld) check("fo_avg_sum", avg_sum, 10050);
      end else begin
        prev2 = -1;
      end
      if (e.tag == 3) begin
        check_rng("mash_dctrl", dctrl, 59, 62);
        if (avg_vld) begin
          check_rng("mash_win_sum", avg_sum, 6024, 6026);
          tot3 += avg_sum;
          win3++;
          if (win3 == 4) check_rng("mash_4win_total", tot3, 24098, 24102);
        end
      end
      if (e.tag == 4) check_rng("sat_hi", dctrl, 510, 511);
      if (e.tag == 5) check_rng("sat_lo", dctrl, 0, 2);
    end
  end

  task automatic restart(int ph, int mode, int fi, int ff);
    phase = 0; en = 1'b0; band_ld = 1'b0;
    dith_mode = mode[1:0]; fcw_int = fi[INT_W-1:0]; fcw_frac = ff[FRAC_W-1:0];
    cycles(1);
    en = 1'b1;
    cycles(1);
    phase = ph;
  endtask

  initial begin
    @(negedge clk);
    rst = 1'b1; en = 1'b1;
    cycles(3);
    rst = 1'b0;
    cycles(3);

    restart(2, 1, 100, 'h80);
    cycles(300);

    restart(3, 2, 60, 'h40);
    cycles(405);

    restart(4, 2, 511, 'hC0);
    cycles(200);
    restart(5, 2, 0, 'h01);
    cycles(600);

    restart(0, 1, 100, 'h55);
    cycles(20);
    band_ld = 1'b1; band_req = 2'd2;
    cycles(1);
    band_ld = 1'b0;
    cycles(5);
    band_ld = 1'b1; band_req = 2'd1;
    cycles(1);
    band_ld = 1'b0;
    cycles(20);
    band_ld = 1'b1; band_req = 2'd3;
    cycles(1);
    band_req = 2'd2;
    cycles(1);
    band_ld = 1'b0;
    cycles(30);

    restart(0, 2, 200, 'h33);
    cycles(50);
    en = 1'b0;
    cycles(1);
    en = 1'b1;
    cycles(250);

    band_ld = 1'b1; band_req = 2'd0;
    cycles(1);
    band_ld = 1'b0;
    cycles(5);
    rst = 1'b1;
    cycles(2);
    rst = 1'b0;
    cycles(20);

    for (int i = 0; i < 2000; i++) begin
      int pick;
      rst = ($urandom_range(0, 499) == 0);
      en = ($urandom_range(0, 49) != 0);
      if ($urandom_range(0, 15) == 0) dith_mode = 2'($urandom_range(0, 3));
      pick = $urandom_range(0, 3);
      fcw_int = (pick == 0) ? 9'd0 : (pick == 1) ? 9'd511 : 9'($urandom_range(0, 511));
      fcw_frac = 8'($urandom_range(0, 255));
      band_ld = ($urandom_range(0, 19) == 0);
      band_req = 2'($urandom_range(0, 3));
      cycles(1);
    end
    rst = 1'b0; en = 1'b1; band_ld = 1'b0;
    cycles(3);
    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
